// File: rtl/life_pkg.sv
// Shared grid constants and the readout FSM state encoding.
package life_pkg;

  localparam int unsigned DEF_ROWS   = 16;
  localparam int unsigned DEF_COLS   = 16;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned PACK_W     = 8;
  localparam int unsigned BIT_CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/life_bit_packer.sv
// Serial-to-byte packer: first shifted cell ends up in the MSB.
module life_bit_packer
  import life_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              clear,
  input  logic              bit_i,
  output logic [PACK_W-1:0] byte_o,
  output logic              full_o
);

  logic [BIT_CNT_W-1:0] bit_cnt;

  // High on the shift that completes the byte, so the FSM can branch on the same edge.
  assign full_o = shift_en && (bit_cnt == BIT_CNT_W'(PACK_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_o  <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      byte_o  <= {byte_o[PACK_W-2:0], bit_i};
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/life_grid_reader.sv
// Streams the cell RAM out as packed bytes over a valid/ready link, one frame per start pulse.
module life_grid_reader
  import life_pkg::*;
#(
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_50MHz_i,
  input  logic              rst_sync_ha_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_re_o,
  input  logic              ram_data_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              tx_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t           state;
  logic [CNT_W-1:0] cell_cnt;
  logic             shift_en;
  logic             pack_clear;
  logic             byte_full;
  logic [7:0]       pack_byte;

  assign shift_en   = (state == ST_LATCH);
  assign pack_clear = ((state == ST_IDLE) && start_i) || ((state == ST_SEND) && tx_ready_i);
  assign tx_data_o  = pack_byte;

  life_bit_packer u_packer (
    .clk      (clk_50MHz_i),
    .rst      (rst_sync_ha_i),
    .shift_en (shift_en),
    .clear    (pack_clear),
    .bit_i    (ram_data_i),
    .byte_o   (pack_byte),
    .full_o   (byte_full)
  );

  // Outputs are set on the transition into the state that owns them.
  always_ff @(posedge clk_50MHz_i) begin
    if (rst_sync_ha_i) begin
      state      <= ST_IDLE;
      cell_cnt   <= '0;
      ram_addr_o <= '0;
      ram_re_o   <= 1'b0;
      tx_valid_o <= 1'b0;
      tx_last_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      ram_re_o <= 1'b0;
      done_o   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            cell_cnt   <= '0;
            ram_addr_o <= '0;
            ram_re_o   <= 1'b1;
            busy_o     <= 1'b1;
            state      <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LATCH;
        ST_LATCH: begin
          cell_cnt <= cell_cnt + CNT_W'(1);
          if (byte_full) begin
            tx_valid_o <= 1'b1;
            tx_last_o  <= (cell_cnt == CNT_W'(CELLS - 1));
            state      <= ST_SEND;
          end else begin
            ram_re_o   <= 1'b1;
            ram_addr_o <= ADDR_W'(cell_cnt + CNT_W'(1));
            state      <= ST_FETCH;
          end
        end
        ST_SEND: begin
          if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            tx_last_o  <= 1'b0;
            if (cell_cnt == CNT_W'(CELLS)) begin
              done_o <= 1'b1;
              state  <= ST_DONE;
            end else begin
              ram_re_o   <= 1'b1;
              ram_addr_o <= cell_cnt[ADDR_W-1:0];
              state      <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          tx_valid_o <= 1'b0;
          tx_last_o  <= 1'b0;
          busy_o     <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_grid_reader.sv
// Directed bench for life_grid_reader with a one-cycle-latency cell RAM model.
module tb_life_grid_reader;

  localparam int unsigned ROWS   = 16;
  localparam int unsigned COLS   = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int CELLS   = 256;
  localparam int NBYTES  = 32;
  localparam int T_FRAME = 2 * CELLS + NBYTES + 1;  // cycle index of done_o after start sample

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re;
  logic              ram_data = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              tx_last;
  logic              busy;
  logic              done;

  logic       mem [CELLS];
  logic [7:0] rx_byte [NBYTES];
  logic       rx_last [NBYTES];
  int n_rx, done_cyc, n_reads, last_addr, addr_err, stall_err, stall_reads, stall_seen;
  int pass_cnt = 0;
  int total_cnt = 0;

  life_grid_reader #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .clk_50MHz_i   (clk),
    .rst_sync_ha_i (rst),
    .start_i       (start),
    .ram_addr_o    (ram_addr),
    .ram_re_o      (ram_re),
    .ram_data_i    (ram_data),
    .tx_data_o     (tx_data),
    .tx_valid_o    (tx_valid),
    .tx_ready_i    (tx_ready),
    .tx_last_o     (tx_last),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (ram_re) ram_data <= mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Start one frame and play consumer until done_o; optional stall and stray start pulse.
  task automatic run_frame(input int stall_byte, input int stall_len, input int poke_at);
    int c;
    logic [7:0] held;
    n_rx = 0; done_cyc = 0; n_reads = 0; last_addr = -1; addr_err = 0;
    stall_err = 0; stall_reads = 0; stall_seen = 0; held = '0;
    tx_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 1;
    while (done_cyc == 0 && c < 3000) begin
      start = (c == poke_at);
      if (ram_re) begin
        if (int'(ram_addr) != n_reads) addr_err++;
        last_addr = int'(ram_addr);
        n_reads++;
      end
      if (done) begin
        done_cyc = c;
      end else if (tx_valid && n_rx == stall_byte && stall_seen < stall_len) begin
        if (stall_seen == 0) held = tx_data;
        else if (tx_data !== held) stall_err++;
        if (ram_re) stall_reads++;
        stall_seen++;
        tx_ready = 1'b0;
      end else if (tx_valid && n_rx < NBYTES) begin
        if (n_rx == stall_byte && stall_len > 0 && tx_data !== held) stall_err++;
        tx_ready = 1'b1;
        rx_byte[n_rx] = tx_data;
        rx_last[n_rx] = tx_last;
        n_rx++;
      end else begin
        tx_ready = 1'b1;
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    tx_ready = 1'b1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_bytes_const(input string tag, input logic [7:0] val);
    int bad, last_bad;
    bad = 0; last_bad = 0;
    for (int i = 0; i < NBYTES; i++) begin
      if (rx_byte[i] !== val) bad++;
      if (rx_last[i] !== (i == NBYTES - 1)) last_bad++;
    end
    check({tag, "_bytes"}, bad, 0);
    check({tag, "_last_only_final"}, last_bad, 0);
  endtask

  initial begin
    int bad, extra;
    logic found;

    for (int k = 0; k < CELLS; k++) mem[k] = 1'(k & 1);

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_ram_re", {31'd0, ram_re}, 32'd0);
    check("rst_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_last_done", {30'd0, tx_last, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Alternating pattern: every byte is 0101_0101.
    run_frame(-1, 0, 0);
    check("f1_nbytes", n_rx, NBYTES);
    check("f1_done_cycle", done_cyc, T_FRAME);
    check("f1_byte0", {24'd0, rx_byte[0]}, 32'h55);
    check("f1_byte31", {24'd0, rx_byte[31]}, 32'h55);
    check_bytes_const("f1", 8'h55);
    check("f1_reads", n_reads, CELLS);
    check("f1_addr_seq", addr_err, 0);
    check("f1_final_addr", last_addr, 32'hFF);

    // Only first and last cell alive.
    for (int k = 0; k < CELLS; k++) mem[k] = 1'b0;
    mem[0] = 1'b1;
    mem[CELLS-1] = 1'b1;
    run_frame(-1, 0, 0);
    check("f2_nbytes", n_rx, NBYTES);
    check("f2_byte0", {24'd0, rx_byte[0]}, 32'h80);
    check("f2_byte31", {24'd0, rx_byte[31]}, 32'h01);
    bad = 0;
    for (int i = 1; i < NBYTES - 1; i++) if (rx_byte[i] !== 8'h00) bad++;
    check("f2_middle_zero", bad, 0);
    check("f2_last_flag", {31'd0, rx_last[31]}, 32'd1);

    // Back-pressure on byte 3 plus a start pulse while busy.
    for (int k = 0; k < CELLS; k++) mem[k] = 1'(k & 1);
    run_frame(3, 5, 100);
    check("f3_stall_cycles", stall_seen, 5);
    check("f3_stall_stable", stall_err, 0);
    check("f3_stall_no_reads", stall_reads, 0);
    check("f3_nbytes", n_rx, NBYTES);
    check_bytes_const("f3", 8'h55);
    check("f3_done_cycle", done_cyc, T_FRAME + 5);
    check("f3_reads", n_reads, CELLS);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || tx_valid || ram_re) extra++;
    end
    check("f3_no_second_frame", extra, 0);

    // Reset while byte 10 is being offered.
    found = 1'b0;
    n_rx = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      if (tx_valid) begin
        if (n_rx == 10) found = 1'b1;
        else n_rx++;
      end
      if (!found) @(negedge clk);
    end
    check("abort_reached_byte10", {31'd0, found}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_flags", {27'd0, tx_valid, busy, ram_re, tx_last, done}, 32'd0);
    check("abort_data_addr", {16'd0, tx_data, ram_addr}, 32'd0);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("abort_no_done", extra, 0);

    run_frame(-1, 0, 0);
    check("f4_restart_addr_seq", addr_err, 0);
    check("f4_nbytes", n_rx, NBYTES);
    check_bytes_const("f4", 8'h55);
    check("f4_done_cycle", done_cyc, T_FRAME);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
